// File: rtl/piso_readout_pkg.sv
// Shared types and default constants for the PISO shift-register readout controller.
package piso_readout_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        HOLD
    } state_t;

    localparam int unsigned DEF_N_CH    = 4;
    localparam int unsigned DEF_N_BITS  = 8;
    localparam int unsigned DEF_CLK_DIV = 2;
    localparam int unsigned DROP_W      = 16;

endpackage

// File: rtl/piso_readout_ctrl_sr_clk_gen.sv
// Shift-clock phase generator: SR_CLK toggles every CLK_DIV cycles while enabled;
// strobes mark the last CLK cycle of each low (sample) and high (edge) phase.
module sr_clk_gen
    import piso_readout_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic CLK,
    input  logic RST,
    input  logic en,
    input  logic clr,
    output logic sr_clk,
    output logic sample_stb,
    output logic edge_stb
);

    localparam int unsigned   DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q;
    logic          phase_end;

    assign phase_end  = en && (div_q == DIV_LAST);
    assign sample_stb = phase_end && !sr_clk;
    assign edge_stb   = phase_end && sr_clk;

    // clr wins over en so the clock parks low on the very edge the run ends
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_q  <= '0;
            sr_clk <= 1'b0;
        end else if (clr) begin
            div_q  <= '0;
            sr_clk <= 1'b0;
        end else if (en) begin
            if (div_q == DIV_LAST) begin
                div_q  <= '0;
                sr_clk <= ~sr_clk;
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/piso_readout_ctrl.sv
// Readout controller for N_CH parallel PISO chains: load, shift out N_BITS, hold frame.
// Optional macro SR_DATA_INVERT_EN stores each sampled SR_Q bit inverted.
module piso_readout_ctrl
    import piso_readout_pkg::*;
#(
    parameter int unsigned       N_CH         = DEF_N_CH,
    parameter int unsigned       N_BITS       = DEF_N_BITS,
    parameter int unsigned       CLK_DIV      = DEF_CLK_DIV,
    // reset value of the rejected-trigger counter; nonzero only to exercise saturation
    parameter logic [DROP_W-1:0] DROP_CNT_RST = '0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     TRIG,
    input  logic [N_CH-1:0]          SR_Q,
    output logic                     SR_CLK,
    output logic                     SR_LOAD,
    output logic [N_CH*N_BITS-1:0]   FRAME_DATA,
    output logic                     FRAME_VALID,
    input  logic                     FRAME_READY,
    output logic                     BUSY,
    output logic [DROP_W-1:0]        DROP_CNT
);

    localparam int unsigned   BW       = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(N_BITS - 1);

    state_t          state_q, state_d;
    logic [BW-1:0]   bit_q;
    logic            gen_en, gen_clr, sample_stb, edge_stb;
    logic            last_bit, handshake;
    logic [N_CH-1:0] samp;

`ifdef SR_DATA_INVERT_EN
    assign samp = ~SR_Q;
`else
    assign samp = SR_Q;
`endif

    assign last_bit  = (bit_q == BIT_LAST);
    assign handshake = FRAME_VALID && FRAME_READY;

    sr_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sr_clk_gen (
        .CLK       (CLK),
        .RST       (RST),
        .en        (gen_en),
        .clr       (gen_clr),
        .sr_clk    (SR_CLK),
        .sample_stb(sample_stb),
        .edge_stb  (edge_stb)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (TRIG)                   state_d = LOAD;
            LOAD:  if (edge_stb)               state_d = SHIFT;
            SHIFT: if (sample_stb && last_bit) state_d = HOLD;
            HOLD:  if (handshake)              state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    // generator runs only while staying inside LOAD/SHIFT, so it starts and stops phase-aligned
    always_comb begin
        BUSY    = (state_q != IDLE);
        gen_en  = (state_q == LOAD) || (state_q == SHIFT);
        gen_clr = !((state_d == LOAD) || (state_d == SHIFT));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            SR_LOAD     <= 1'b0;
            FRAME_VALID <= 1'b0;
            FRAME_DATA  <= '0;
            bit_q       <= '0;
            DROP_CNT    <= DROP_CNT_RST;
        end else begin
            SR_LOAD     <= (state_d == LOAD);
            FRAME_VALID <= (state_q == HOLD) && !handshake;

            if (state_q != SHIFT) begin
                bit_q <= '0;
            end else if (sample_stb) begin
                bit_q <= bit_q + 1'b1;
                // sample k lands in bit N_BITS-1-k of every chain field
                for (int unsigned c = 0; c < N_CH; c++) begin
                    for (int unsigned b = 0; b < N_BITS; b++) begin
                        if (bit_q == BW'(N_BITS - 1 - b)) begin
                            FRAME_DATA[c*N_BITS + b] <= samp[c];
                        end
                    end
                end
            end

            if (TRIG && (state_q != IDLE) && (DROP_CNT != '1)) begin
                DROP_CNT <= DROP_CNT + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_piso_readout_ctrl.sv
// Self-checking bench for piso_readout_ctrl with behavioural inverting-load chain models.
module tb_piso_readout_ctrl;

    localparam int unsigned N_CH    = 2;
    localparam int unsigned N_BITS  = 8;
    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned LAT     = (2*N_BITS + 1)*CLK_DIV + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        trig, frame_ready;
    logic [1:0]  sr_q;
    logic        sr_clk, sr_load, frame_valid, busy;
    logic [15:0] frame_data, drop_cnt;

    logic        trig_b, frame_ready_b;
    logic [1:0]  sr_q_b = '0;
    logic        sr_clk_b, sr_load_b, frame_valid_b, busy_b;
    logic [15:0] frame_data_b, drop_cnt_b;

    logic [7:0]  d0, d1;
    logic [7:0]  ch0 = '0, ch1 = '0;

    int unsigned errors = 0, checks = 0, cyc = 0;
    int unsigned load_edges = 0, shift_edges = 0, width_bad = 0;
    int unsigned hi_run = 0, lo_run = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    piso_readout_ctrl #(
        .N_CH(N_CH), .N_BITS(N_BITS), .CLK_DIV(CLK_DIV)
    ) dut (
        .CLK(clk), .RST(rst), .TRIG(trig), .SR_Q(sr_q), .SR_CLK(sr_clk), .SR_LOAD(sr_load),
        .FRAME_DATA(frame_data), .FRAME_VALID(frame_valid), .FRAME_READY(frame_ready),
        .BUSY(busy), .DROP_CNT(drop_cnt)
    );

    piso_readout_ctrl #(
        .N_CH(N_CH), .N_BITS(N_BITS), .CLK_DIV(CLK_DIV), .DROP_CNT_RST(16'hFFF0)
    ) dut_sat (
        .CLK(clk), .RST(rst), .TRIG(trig_b), .SR_Q(sr_q_b), .SR_CLK(sr_clk_b), .SR_LOAD(sr_load_b),
        .FRAME_DATA(frame_data_b), .FRAME_VALID(frame_valid_b), .FRAME_READY(frame_ready_b),
        .BUSY(busy_b), .DROP_CNT(drop_cnt_b)
    );

    // chains: inverting parallel load, MSB-first shift out
    always @(posedge sr_clk) begin
        if (sr_load) begin
            ch0 <= ~d0;
            ch1 <= ~d1;
        end else begin
            ch0 <= {ch0[6:0], 1'b0};
            ch1 <= {ch1[6:0], 1'b0};
        end
    end
    assign sr_q = {ch1[7], ch0[7]};

    always @(posedge sr_clk) begin
        if (sr_load) load_edges  <= load_edges + 1;
        else         shift_edges <= shift_edges + 1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // SR_CLK phase widths while busy: every high run and every low run ending in a rise
    always @(negedge clk) begin
        if (rst || !busy) begin
            hi_run <= 0;
            lo_run <= 0;
        end else if (sr_clk) begin
            if (hi_run == 0 && lo_run != CLK_DIV) width_bad <= width_bad + 1;
            hi_run <= hi_run + 1;
            lo_run <= 0;
        end else begin
            if (hi_run != 0 && hi_run != CLK_DIV) width_bad <= width_bad + 1;
            lo_run <= lo_run + 1;
            hi_run <= 0;
        end
    end

    function automatic logic [15:0] exp_frame(input logic [7:0] a, input logic [7:0] b);
`ifdef SR_DATA_INVERT_EN
        return {b, a};
`else
        return ~{b, a};
`endif
    endfunction

    task automatic wait_valid(input int unsigned limit, output bit ok);
        ok = 1'b0;
        for (int unsigned i = 0; i < limit; i++) begin
            if (frame_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (frame_valid) ok = 1'b1;
    endtask

    task automatic test_reset();
        bit ok;
        int unsigned t0;
        logic [15:0] e;
        rst = 1'b1; trig = 1'b0; frame_ready = 1'b0;
        trig_b = 1'b0; frame_ready_b = 1'b0; d0 = '0; d1 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({sr_clk, sr_load, frame_valid, busy} !== 4'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 0000", {sr_clk, sr_load, frame_valid, busy});
        end
        checks++;
        if (frame_data !== 16'h0) begin
            errors++; $display("FAIL reset_data: got %h expected 0000", frame_data);
        end
        checks++;
        if (drop_cnt !== 16'h0) begin
            errors++; $display("FAIL reset_drop: got %h expected 0000", drop_cnt);
        end
        checks++;
        if (drop_cnt_b !== 16'hFFF0) begin
            errors++; $display("FAIL reset_drop_preload: got %h expected fff0", drop_cnt_b);
        end
        // trigger on the very first edge with reset released
        rst = 1'b0; d0 = 8'hA5; d1 = 8'h3C; trig = 1'b1;
        exp_q.push_back(exp_frame(d0, d1));
        @(negedge clk);
        trig = 1'b0; t0 = cyc;
        checks++;
        if ({busy, sr_load} !== 2'b11) begin
            errors++; $display("FAIL first_trig: got busy,load=%b expected 11", {busy, sr_load});
        end
        wait_valid(100, ok);
        checks++;
        if (!ok || (cyc - t0) != LAT) begin
            errors++; $display("FAIL first_latency: got %0d expected %0d", cyc - t0, LAT);
        end
        e = exp_q.pop_front();
        checks++;
        if (frame_data !== e) begin
            errors++; $display("FAIL first_data: got %h expected %h", frame_data, e);
        end
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
    endtask

    task automatic test_frame(input logic [7:0] a, input logic [7:0] b);
        bit ok;
        int unsigned t0, le0, se0, wb0;
        logic [15:0] e;
        le0 = load_edges; se0 = shift_edges; wb0 = width_bad;
        d0 = a; d1 = b; trig = 1'b1;
        exp_q.push_back(exp_frame(a, b));
        @(negedge clk);
        trig = 1'b0; t0 = cyc;
        wait_valid(100, ok);
        checks++;
        if (!ok || (cyc - t0) != LAT) begin
            errors++; $display("FAIL frame_latency: got %0d expected %0d", cyc - t0, LAT);
        end
        e = exp_q.pop_front();
        checks++;
        if (frame_data !== e) begin
            errors++; $display("FAIL frame_data: got %h expected %h", frame_data, e);
        end
        checks++;
        if (load_edges - le0 != 1 || shift_edges - se0 != N_BITS - 1) begin
            errors++; $display("FAIL frame_edges: got load=%0d shift=%0d expected 1 and %0d",
                               load_edges - le0, shift_edges - se0, N_BITS - 1);
        end
        checks++;
        if (width_bad != wb0) begin
            errors++; $display("FAIL frame_widths: got %0d bad phases expected 0", width_bad - wb0);
        end
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
        checks++;
        if ({frame_valid, busy} !== 2'b00) begin
            errors++; $display("FAIL frame_handshake: got valid,busy=%b expected 00", {frame_valid, busy});
        end
    endtask

    task automatic test_hold();
        bit ok;
        int unsigned bad = 0;
        logic [15:0] e, snap, dc0;
        d0 = 8'hC3; d1 = 8'h5A; trig = 1'b1;
        exp_q.push_back(exp_frame(d0, d1));
        @(negedge clk);
        trig = 1'b0;
        wait_valid(100, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || frame_data !== e) begin
            errors++; $display("FAIL hold_data: got %h expected %h", frame_data, e);
        end
        snap = frame_data; dc0 = drop_cnt;
        for (int unsigned i = 0; i < 20; i++) begin
            trig = (i == 3 || i == 8 || i == 14);
            @(negedge clk);
            if (frame_data !== snap || frame_valid !== 1'b1) bad++;
        end
        trig = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL hold_stable: got %0d unstable cycles expected 0", bad);
        end
        checks++;
        if (drop_cnt !== dc0 + 16'd3) begin
            errors++; $display("FAIL hold_drops: got %h expected %h", drop_cnt, dc0 + 16'd3);
        end
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
        d0 = 8'h0F; d1 = 8'hF0; trig = 1'b1;
        exp_q.push_back(exp_frame(d0, d1));
        @(negedge clk);
        trig = 1'b0;
        checks++;
        if (busy !== 1'b1 || drop_cnt !== dc0 + 16'd3) begin
            errors++; $display("FAIL after_handshake_trig: got busy=%b drop=%h expected 1 %h",
                               busy, drop_cnt, dc0 + 16'd3);
        end
        wait_valid(100, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || frame_data !== e) begin
            errors++; $display("FAIL after_handshake_data: got %h expected %h", frame_data, e);
        end
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int unsigned t0, vbad = 0;
        d0 = 8'hA5; d1 = 8'h3C; trig = 1'b1;
        exp_q.push_back(exp_frame(d0, d1));
        @(negedge clk);
        trig = 1'b0; t0 = cyc;
        // SHIFT starts 2*CLK_DIV cycles after acceptance; stop 12 cycles in
        while (cyc < t0 + 2*CLK_DIV + 12) @(negedge clk);
        checks++;
        if (frame_data === 16'h0 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_partial: got data=%h busy=%b expected nonzero 1", frame_data, busy);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({sr_clk, sr_load, frame_valid, busy} !== 4'b0 || frame_data !== 16'h0 || drop_cnt !== 16'h0) begin
            errors++; $display("FAIL mid_reset: got ctrl=%b data=%h drop=%h expected 0",
                               {sr_clk, sr_load, frame_valid, busy}, frame_data, drop_cnt);
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int unsigned i = 0; i < 60; i++) begin
            @(negedge clk);
            if (frame_valid !== 1'b0) vbad++;
        end
        checks++;
        if (vbad != 0) begin
            errors++; $display("FAIL mid_no_valid: got %0d valid cycles expected 0", vbad);
        end
        test_frame(8'h96, 8'h69);
    endtask

    task automatic test_back_to_back();
        int unsigned exp_drops = 0, frames = 0, bad = 0;
        logic [15:0] dc0, e;
        frame_ready = 1'b1;
        dc0 = drop_cnt;
        for (int unsigned i = 0; i < 100; i++) begin
            if (frame_valid) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
                if (frame_data !== e) bad++;
                frames++;
            end
            trig = 1'b1;
            if (busy) begin
                exp_drops++;
            end else begin
                d0 = 8'($urandom); d1 = 8'($urandom);
                exp_q.push_back(exp_frame(d0, d1));
            end
            @(negedge clk);
        end
        trig = 1'b0;
        for (int unsigned i = 0; i < 100 && exp_q.size() != 0; i++) begin
            if (frame_valid) begin
                e = exp_q.pop_front();
                if (frame_data !== e) bad++;
                frames++;
            end
            @(negedge clk);
        end
        frame_ready = 1'b0;
        checks++;
        if (bad != 0 || exp_q.size() != 0) begin
            errors++; $display("FAIL b2b_data: got %0d bad, %0d missing expected 0 0", bad, exp_q.size());
        end
        checks++;
        if (frames < 2) begin
            errors++; $display("FAIL b2b_frames: got %0d expected >= 2", frames);
        end
        checks++;
        if (drop_cnt !== dc0 + 16'(exp_drops)) begin
            errors++; $display("FAIL b2b_drops: got %h expected %h", drop_cnt, dc0 + 16'(exp_drops));
        end
    endtask

    task automatic test_saturation();
        logic [15:0] exp;
        int unsigned bad = 0;
        exp = drop_cnt_b;
        frame_ready_b = 1'b1;
        for (int unsigned i = 0; i < 60; i++) begin
            trig_b = 1'b1;
            if (busy_b && exp != 16'hFFFF) exp = exp + 16'd1;
            @(negedge clk);
            if (drop_cnt_b !== exp) bad++;
        end
        trig_b = 1'b0; frame_ready_b = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL sat_track: got %0d cycles off model expected 0", bad);
        end
        checks++;
        if (drop_cnt_b !== 16'hFFFF) begin
            errors++; $display("FAIL sat_final: got %h expected ffff", drop_cnt_b);
        end
    endtask

    initial begin
        test_reset();
        test_frame(8'hA5, 8'h3C);
        test_frame(8'hFF, 8'h00);
        test_frame(8'h81, 8'h7E);
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
